demux_2_steer: RTL and testbench

Registered 1-to-2 demultiplexer with valid/ready handshaking, the steering counterpart of the 2:1 multiplexer used across the DECODE gate array. It accepts one word per cycle from a single upstream source and routes it, according to a per-word select, into one of two single-entry output slots, each drained independently by its consumer. Per-channel transfer counters support bus-trace and diagnostics logic.

---
 rtl/demux_2_steer_pkg.sv | 16 +
 rtl/demux_slot.sv | 57 +++++
 rtl/demux_2_steer.sv | 73 +++++++
 tb/tb_demux_2_steer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_2_steer_pkg.sv
// Shared select encodings, default widths and slot state for the 1:2 steering demux.
// Imported by the top level and by each output slot.
package demux_2_steer_pkg;

  localparam logic DEMUX_SEL_CH0 = 1'b0;
  localparam logic DEMUX_SEL_CH1 = 1'b1;

  localparam int DEMUX_WIDTH = 16;
  localparam int DEMUX_CNT_W = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slotState_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready output register; a word loaded at edge k is visible in cycle k+1.
// Backpressure: canLoad drops only while full and the consumer stalls; data is frozen then.
module demux_slot
  import demux_2_steer_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic [WIDTH-1:0] loadData,
  output logic             canLoad,
  input  logic             drainReady,
  output logic [WIDTH-1:0] slotData,
  output logic             slotValid
);

  slotState_t state;
  slotState_t stateNext;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    canLoad   = 1'b0;
    case (state)
      SLOT_EMPTY: begin
        canLoad = 1'b1;
        if (load) stateNext = SLOT_FULL;
      end
      SLOT_FULL: begin
        // A draining slot can take a new word in the same cycle.
        canLoad = drainReady;
        if (drainReady && !load) stateNext = SLOT_EMPTY;
      end
      default: stateNext = SLOT_EMPTY;
    endcase
  end

  // Data only moves on a load, so it holds across drains and stalls.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slotData <= '0;
    end else if (load) begin
      slotData <= loadData;
    end
  end

  assign slotValid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_2_steer.sv
// Registered 1:2 demux steering each word by in_sel into one of two slots, one cycle latency.
// in_ready follows only the selected slot, so a stalled channel never blocks the other.
module demux_2_steer
  import demux_2_steer_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CNT_W = DEMUX_CNT_W
) (
  input  logic             sysclk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic canLoad0;
  logic canLoad1;
  logic targetFree;
  logic xfer;
  logic load0;
  logic load1;

  assign targetFree = (in_sel == DEMUX_SEL_CH1) ? canLoad1 : canLoad0;
  // Gating with reset keeps the upstream from seeing a ready while slots are held clear.
  assign in_ready   = sys_rst_n & enable & targetFree;
  assign xfer       = in_valid & in_ready;
  assign load0      = xfer & (in_sel == DEMUX_SEL_CH0);
  assign load1      = xfer & (in_sel == DEMUX_SEL_CH1);

  demux_slot #(.WIDTH(WIDTH)) uSlot0 (
    .clk        (sysclk),
    .rstN       (sys_rst_n),
    .load       (load0),
    .loadData   (in_data),
    .canLoad    (canLoad0),
    .drainReady (out0_ready),
    .slotData   (out0_data),
    .slotValid  (out0_valid)
  );

  demux_slot #(.WIDTH(WIDTH)) uSlot1 (
    .clk        (sysclk),
    .rstN       (sys_rst_n),
    .load       (load1),
    .loadData   (in_data),
    .canLoad    (canLoad1),
    .drainReady (out1_ready),
    .slotData   (out1_data),
    .slotValid  (out1_valid)
  );

  // Counters track accepted input words only; they wrap naturally.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (load0) cnt0 <= cnt0 + 1'b1;
      if (load1) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_2_steer.sv
// Directed bench for demux_2_steer: reset, routing, stall isolation, back-to-back, enable, wrap.
module tb_demux_2_steer;

  logic        sysclk;
  logic        sys_rst_n;
  logic        enable;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int nChecks = 0;
  int nPass   = 0;
  logic [7:0] expCnt0 = 8'd0;
  logic [7:0] expCnt1 = 8'd0;

  demux_2_steer #(.WIDTH(16), .CNT_W(8)) dut (
    .sysclk     (sysclk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic s, input logic v);
    in_data  = d;
    in_sel   = s;
    in_valid = v;
    #1;
  endtask

  task automatic test_reset();
    // Fill both slots with stalled consumers, then reset mid-cycle.
    out0_ready = 1'b0; out1_ready = 1'b0; enable = 1'b1;
    drive(16'h5A5A, 1'b0, 1'b1); tick();
    drive(16'hA5A5, 1'b1, 1'b1); tick();
    nChecks++;
    if ({out0_valid, out1_valid, out0_data, out1_data} !== {2'b11, 16'h5A5A, 16'hA5A5})
      $display("FAIL rst_prefill: got %b%b %h %h expected 11 5a5a a5a5", out0_valid, out1_valid, out0_data, out1_data);
    else nPass++;
    drive(16'h1234, 1'b0, 1'b1);
    #2 sys_rst_n = 1'b0;
    #1;
    nChecks++;
    if ({out0_valid, out1_valid} !== 2'b00)
      $display("FAIL rst_valids: got %b%b expected 00", out0_valid, out1_valid);
    else nPass++;
    nChecks++;
    if ({out0_data, out1_data} !== 32'h0)
      $display("FAIL rst_data: got %h %h expected 0000 0000", out0_data, out1_data);
    else nPass++;
    nChecks++;
    if ({cnt0, cnt1} !== 16'h0)
      $display("FAIL rst_cnt: got %h %h expected 00 00", cnt0, cnt1);
    else nPass++;
    nChecks++;
    if (in_ready !== 1'b0)
      $display("FAIL rst_in_ready: got %b expected 0", in_ready);
    else nPass++;
    @(negedge sysclk);
    sys_rst_n = 1'b1;
    drive(16'h7777, 1'b0, 1'b1);
    nChecks++;
    if (in_ready !== 1'b1)
      $display("FAIL rst_release_ready: got %b expected 1", in_ready);
    else nPass++;
    tick();
    drive(16'h0000, 1'b0, 1'b0);
    nChecks++;
    if ({out0_valid, out0_data, cnt0} !== {1'b1, 16'h7777, 8'd1})
      $display("FAIL rst_first_accept: got %b %h %h expected 1 7777 01", out0_valid, out0_data, cnt0);
    else nPass++;
    expCnt0 = 8'd1; expCnt1 = 8'd0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
  endtask

  task automatic test_alternating();
    out0_ready = 1'b1; out1_ready = 1'b1; enable = 1'b1;
    drive(16'h1111, 1'b0, 1'b1);
    nChecks++;
    if (in_ready !== 1'b1) $display("FAIL alt_ready: got %b expected 1", in_ready);
    else nPass++;
    tick();
    nChecks++;
    if ({out0_valid, out0_data} !== {1'b1, 16'h1111})
      $display("FAIL alt_w1: got %b %h expected 1 1111", out0_valid, out0_data);
    else nPass++;
    drive(16'h2222, 1'b1, 1'b1); tick();
    nChecks++;
    if ({out1_valid, out1_data, out0_valid} !== {1'b1, 16'h2222, 1'b0})
      $display("FAIL alt_w2: got %b %h v0=%b expected 1 2222 v0=0", out1_valid, out1_data, out0_valid);
    else nPass++;
    drive(16'h3333, 1'b0, 1'b1); tick();
    drive(16'h0000, 1'b0, 1'b0);
    nChecks++;
    if ({out0_valid, out0_data, out1_valid} !== {1'b1, 16'h3333, 1'b0})
      $display("FAIL alt_w3: got %b %h v1=%b expected 1 3333 v1=0", out0_valid, out0_data, out1_valid);
    else nPass++;
    expCnt0 = expCnt0 + 8'd2; expCnt1 = expCnt1 + 8'd1;
    nChecks++;
    if ({cnt0, cnt1} !== {expCnt0, expCnt1})
      $display("FAIL alt_cnt: got %h %h expected %h %h", cnt0, cnt1, expCnt0, expCnt1);
    else nPass++;
    tick();
  endtask

  task automatic test_stall();
    out0_ready = 1'b0; out1_ready = 1'b1;
    drive(16'hAAAA, 1'b0, 1'b1); tick();
    drive(16'hBBBB, 1'b0, 1'b1);
    nChecks++;
    if (in_ready !== 1'b0) $display("FAIL stall_blocked: got %b expected 0", in_ready);
    else nPass++;
    tick();
    nChecks++;
    if ({out0_valid, out0_data} !== {1'b1, 16'hAAAA})
      $display("FAIL stall_hold: got %b %h expected 1 aaaa", out0_valid, out0_data);
    else nPass++;
    drive(16'hCCCC, 1'b1, 1'b1);
    nChecks++;
    if (in_ready !== 1'b1) $display("FAIL stall_other_ready: got %b expected 1", in_ready);
    else nPass++;
    tick();
    drive(16'h0000, 1'b0, 1'b0);
    nChecks++;
    if ({out1_valid, out1_data, out0_valid, out0_data} !== {1'b1, 16'hCCCC, 1'b1, 16'hAAAA})
      $display("FAIL stall_cross: got %b %h %b %h expected 1 cccc 1 aaaa", out1_valid, out1_data, out0_valid, out0_data);
    else nPass++;
    expCnt0 = expCnt0 + 8'd1; expCnt1 = expCnt1 + 8'd1;
    out0_ready = 1'b1; tick();
    nChecks++;
    if ({out0_valid, out1_valid, cnt0, cnt1} !== {2'b00, expCnt0, expCnt1})
      $display("FAIL stall_drain: got %b%b %h %h expected 00 %h %h", out0_valid, out1_valid, cnt0, cnt1, expCnt0, expCnt1);
    else nPass++;
  endtask

  task automatic test_back_to_back();
    out1_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(16'(i), 1'b1, 1'b1);
      tick();
      nChecks++;
      if ({out1_valid, out1_data} !== {1'b1, 16'(i)})
        $display("FAIL b2b_word%0d: got %b %h expected 1 %h", i, out1_valid, out1_data, 16'(i));
      else nPass++;
    end
    drive(16'h0000, 1'b0, 1'b0);
    expCnt1 = expCnt1 + 8'd4;
    nChecks++;
    if (cnt1 !== expCnt1) $display("FAIL b2b_cnt1: got %h expected %h", cnt1, expCnt1);
    else nPass++;
    tick();
    nChecks++;
    if ({out1_valid, out1_data} !== {1'b0, 16'h0004})
      $display("FAIL b2b_drain: got %b %h expected 0 0004", out1_valid, out1_data);
    else nPass++;
  endtask

  task automatic test_enable();
    out0_ready = 1'b0; out1_ready = 1'b0; enable = 1'b1;
    drive(16'h0E0E, 1'b0, 1'b1); tick();
    drive(16'h0F0F, 1'b1, 1'b1); tick();
    expCnt0 = expCnt0 + 8'd1; expCnt1 = expCnt1 + 8'd1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    enable = 1'b0;
    drive(16'hDEAD, 1'b0, 1'b1);
    nChecks++;
    if (in_ready !== 1'b0) $display("FAIL en_ready_sel0: got %b expected 0", in_ready);
    else nPass++;
    out0_ready = 1'b0; out1_ready = 1'b0;
    drive(16'hDEAD, 1'b1, 1'b1);
    nChecks++;
    if (in_ready !== 1'b0) $display("FAIL en_ready_sel1: got %b expected 0", in_ready);
    else nPass++;
    tick(); tick();
    nChecks++;
    if ({out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1} !== {1'b1, 16'h0E0E, 1'b1, 16'h0F0F, expCnt0, expCnt1})
      $display("FAIL en_frozen: got %b %h %b %h %h %h expected 1 0e0e 1 0f0f %h %h",
               out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1, expCnt0, expCnt1);
    else nPass++;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    nChecks++;
    if ({out0_valid, out1_valid, out0_data, cnt0, cnt1} !== {2'b00, 16'h0E0E, expCnt0, expCnt1})
      $display("FAIL en_drain: got %b%b %h %h %h expected 00 0e0e %h %h",
               out0_valid, out1_valid, out0_data, cnt0, cnt1, expCnt0, expCnt1);
    else nPass++;
    drive(16'h0000, 1'b0, 1'b0);
    enable = 1'b1;
  endtask

  task automatic test_wrap();
    #2 sys_rst_n = 1'b0;
    @(negedge sysclk);
    sys_rst_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(16'(i), 1'b0, 1'b1);
      tick();
      if (i == 127) begin
        nChecks++;
        if (cnt0 !== 8'h80) $display("FAIL wrap_half: got %h expected 80", cnt0);
        else nPass++;
      end
      if (i == 254) begin
        nChecks++;
        if (cnt0 !== 8'hFF) $display("FAIL wrap_max: got %h expected ff", cnt0);
        else nPass++;
      end
    end
    drive(16'h0000, 1'b0, 1'b0);
    nChecks++;
    if ({cnt0, cnt1} !== 16'h0000) $display("FAIL wrap_zero: got %h %h expected 00 00", cnt0, cnt1);
    else nPass++;
    nChecks++;
    if ({out0_valid, out0_data} !== {1'b1, 16'h00FF})
      $display("FAIL wrap_load: got %b %h expected 1 00ff", out0_valid, out0_data);
    else nPass++;
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    enable     = 1'b1;
    in_data    = 16'h0000;
    in_sel     = 1'b0;
    in_valid   = 1'b1;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #3;
    nChecks++;
    if ({in_ready, out0_valid, out1_valid, cnt0, cnt1} !== 19'h0)
      $display("FAIL init_reset: got rdy=%b v=%b%b cnt=%h %h expected all 0", in_ready, out0_valid, out1_valid, cnt0, cnt1);
    else nPass++;
    in_valid = 1'b0;
    #9 sys_rst_n = 1'b1;
    tick();

    test_reset();
    test_alternating();
    test_stall();
    test_back_to_back();
    test_enable();
    test_wrap();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
